// File: rtl/vram_arbiter.sv
// vram_arbiter
//
// Shares one single-port VRAM between the PPU fetcher, the OAM DMA engine
// and the CPU bus. Priority is PPU > DMA > CPU. A CPU that has waited
// STARVE_LIMIT cycles is lifted above DMA, but never above the PPU.
// While the PPU holds vram_access, a CPU access completes without touching
// memory: blocked reads return 8'hFF and blocked writes are dropped.
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   vram_access                  PPU lock, restricts the CPU only
//   ppu_req/ppu_addr             PPU read, one cycle per access, always granted
//   ppu_gnt/ppu_rvalid/ppu_rdata grant (comb), data valid one cycle later
//   dma_req/dma_addr             DMA read, held until granted
//   dma_gnt/dma_rvalid/dma_rdata grant (comb), data valid one cycle later
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request, sampled in C_IDLE only
//   cpu_ack/cpu_rdata            completion pulse, read result (held)
//   mem_addr/mem_wdata/mem_wren/mem_q  VRAM port, registered read (1 cycle)
module vram_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vram_access,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_gnt,
    output logic              ppu_rvalid,
    output logic [7:0]        ppu_rdata,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [7:0]        dma_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_wren,
    input  logic [7:0]        mem_q
);

    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_READ, C_DONE} cpu_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_PPU, OWN_DMA, OWN_CPU} owner_t;

    localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);

    cpu_state_t        state_reg, state_next;
    owner_t            owner_reg, owner_next;
    logic [3:0]        starve_cnt_reg, starve_cnt_next;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        wdata_reg;
    logic              blocked_reg;
    logic              ppu_rvalid_reg, dma_rvalid_reg;
    logic [7:0]        cpu_rdata_reg;
    logic [ADDR_W-1:0] mem_addr_reg;

    logic starved;
    logic cpu_cand;
    logic cpu_win;

    // ---------------- arbitration ----------------
    assign starved  = (starve_cnt_reg >= STARVE_LIM4);
    assign cpu_cand = (state_reg == C_WAIT) && !vram_access;
    assign cpu_win  = cpu_cand && !ppu_req && (!dma_req || starved);
    assign ppu_gnt  = ppu_req;
    assign dma_gnt  = dma_req && !ppu_req && !(cpu_cand && starved);

    // ---------------- memory drive ----------------
    // Address is combinational so the registered RAM returns data on the
    // cycle after the grant; with no winner the previous address is held.
    always_comb begin
        mem_addr = mem_addr_reg;
        if (ppu_gnt)
            mem_addr = ppu_addr;
        else if (dma_gnt)
            mem_addr = dma_addr;
        else if (cpu_win)
            mem_addr = addr_reg;
    end

    assign mem_wren  = cpu_win && we_reg && !reset;
    assign mem_wdata = wdata_reg;

    // ---------------- read-data routing ----------------
    assign ppu_rvalid = ppu_rvalid_reg;
    assign dma_rvalid = dma_rvalid_reg;
    assign ppu_rdata  = (owner_reg == OWN_PPU) ? mem_q : 8'h00;
    assign dma_rdata  = (owner_reg == OWN_DMA) ? mem_q : 8'h00;

    always_comb begin
        owner_next = OWN_NONE;
        if (ppu_gnt)
            owner_next = OWN_PPU;
        else if (dma_gnt)
            owner_next = OWN_DMA;
        else if (cpu_win)
            owner_next = OWN_CPU;
    end

    // ---------------- CPU FSM ----------------
    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        case (state_reg)
            C_IDLE: begin
                if (cpu_req)
                    state_next = C_WAIT;
            end
            C_WAIT: begin
                if (vram_access) begin
                    state_next      = C_DONE;
                    starve_cnt_next = 4'd0;
                end else if (cpu_win) begin
                    state_next      = we_reg ? C_DONE : C_READ;
                    starve_cnt_next = 4'd0;
                end else if (starve_cnt_reg != 4'hF) begin
                    starve_cnt_next = starve_cnt_reg + 4'd1;
                end
            end
            C_READ:  state_next = C_IDLE;
            C_DONE:  state_next = C_IDLE;
            default: state_next = C_IDLE;
        endcase
    end

    assign cpu_ack = !reset && ((state_reg == C_READ) || (state_reg == C_DONE));

    // Read data is presented on the ack cycle itself and then held in
    // cpu_rdata_reg until the next completed read.
    always_comb begin
        cpu_rdata = cpu_rdata_reg;
        if (state_reg == C_READ)
            cpu_rdata = mem_q;
        else if (state_reg == C_DONE && blocked_reg && !we_reg)
            cpu_rdata = 8'hFF;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= C_IDLE;
            owner_reg      <= OWN_NONE;
            starve_cnt_reg <= 4'd0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= 8'h00;
            blocked_reg    <= 1'b0;
            ppu_rvalid_reg <= 1'b0;
            dma_rvalid_reg <= 1'b0;
            cpu_rdata_reg  <= 8'h00;
            mem_addr_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            starve_cnt_reg <= starve_cnt_next;
            ppu_rvalid_reg <= ppu_gnt;
            dma_rvalid_reg <= dma_gnt;
            cpu_rdata_reg  <= cpu_rdata;
            mem_addr_reg   <= mem_addr;
            if (state_reg == C_IDLE && cpu_req) begin
                we_reg      <= cpu_we;
                addr_reg    <= cpu_addr;
                wdata_reg   <= cpu_wdata;
                blocked_reg <= 1'b0;
            end
            if (state_reg == C_WAIT && vram_access)
                blocked_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed scenarios followed by random traffic.
// Expected responses are queued when requests are issued/granted; a monitor
// on the falling edge pops and compares whenever the DUT presents data.
module tb_vram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        vram_access;
    logic        ppu_req;
    logic [12:0] ppu_addr;
    logic        ppu_gnt, ppu_rvalid;
    logic [7:0]  ppu_rdata;
    logic        dma_req;
    logic [12:0] dma_addr;
    logic        dma_gnt, dma_rvalid;
    logic [7:0]  dma_rdata;
    logic        cpu_req, cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wren;
    logic [7:0]  mem_q;

    vram_arbiter dut (
        .clock(clock), .reset(reset), .vram_access(vram_access),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_gnt(ppu_gnt),
        .ppu_rvalid(ppu_rvalid), .ppu_rdata(ppu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        if (i == 16) return 8'h5A;
        return 8'((i * 7 + 3) & 255);
    endfunction

    // VRAM instance model: registered read, write-first not needed (one port)
    logic [7:0] vram [0:8191];
    logic       init_mem;
    always @(posedge clock) begin
        if (init_mem) begin
            for (int i = 0; i < 8192; i++) vram[i] <= pat(i);
        end else begin
            if (mem_wren) vram[mem_addr] <= mem_wdata;
            mem_q <= vram[mem_addr];
        end
    end

    // Reference memory, updated only by acknowledged, unblocked CPU writes
    logic [7:0] ref_mem [0:8191];

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
        logic        blk;
    } cpu_ent_t;

    cpu_ent_t   cpu_q[$];
    logic [7:0] ppu_q[$];
    logic [7:0] dma_q[$];
    logic       ppu_gnt_d = 1'b0;
    logic       dma_gnt_d = 1'b0;
    logic       wren_seen = 1'b0;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (reset) begin
            cpu_q.delete();
            ppu_q.delete();
            dma_q.delete();
            ppu_gnt_d = 1'b0;
            dma_gnt_d = 1'b0;
        end else begin
            if (ppu_rvalid || ppu_gnt_d)
                chk("ppu_rvalid_follows_gnt", int'(ppu_rvalid), int'(ppu_gnt_d));
            if (ppu_rvalid) begin
                if (ppu_q.size() == 0) chk("ppu_unexpected_rvalid", 1, 0);
                else chk("ppu_rdata", int'(ppu_rdata), int'(ppu_q.pop_front()));
            end
            if (dma_rvalid || dma_gnt_d)
                chk("dma_rvalid_follows_gnt", int'(dma_rvalid), int'(dma_gnt_d));
            if (dma_rvalid) begin
                if (dma_q.size() == 0) chk("dma_unexpected_rvalid", 1, 0);
                else chk("dma_rdata", int'(dma_rdata), int'(dma_q.pop_front()));
            end
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    chk("cpu_unexpected_ack", 1, 0);
                end else begin
                    cpu_ent_t e;
                    e = cpu_q.pop_front();
                    if (!e.we) chk("cpu_rdata", int'(cpu_rdata), int'(e.exp));
                    else if (!e.blk) ref_mem[e.addr] = e.wdata;
                end
            end
            chk("one_winner", int'(int'(ppu_gnt) + int'(dma_gnt) + int'(dut.cpu_win) <= 1), 1);
            if (mem_wren) wren_seen = 1'b1;
            if (ppu_gnt) ppu_q.push_back(ref_mem[ppu_addr]);
            if (dma_gnt) dma_q.push_back(ref_mem[dma_addr]);
            ppu_gnt_d = ppu_gnt;
            dma_gnt_d = dma_gnt;
        end
    end

    // Issue one CPU transaction; lat = cycles from request to ack (-1 = timeout)
    task automatic cpu_txn(input logic we, input logic [12:0] addr, input logic [7:0] wd,
                           input logic blk, output int lat, output logic [7:0] rd);
        cpu_ent_t e;
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        e.we = we; e.addr = addr; e.wdata = wd; e.blk = blk;
        e.exp = blk ? 8'hFF : ref_mem[addr];
        cpu_q.push_back(e);
        lat = -1;
        rd  = 8'h00;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (cpu_ack) begin
                lat = n;
                rd  = cpu_rdata;
                break;
            end
            if (n == 0) begin
                @(posedge clock); #1;
                cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int          lat;
    logic [7:0]  rd;
    logic [24:0] gvec;
    int          ack_cnt;
    logic        cpu_busy;
    logic        dma_seen;

    initial begin
        for (int i = 0; i < 8192; i++) ref_mem[i] = pat(i);
        reset = 1'b1; init_mem = 1'b1;
        vram_access = 1'b0;
        ppu_req = 1'b0; ppu_addr = '0;
        dma_req = 1'b0; dma_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        @(posedge clock); #1; init_mem = 1'b0;
        repeat (2) @(posedge clock);
        #1; reset = 1'b0;

        // reset values
        @(negedge clock);
        chk("rst_cpu_ack", int'(cpu_ack), 0);
        chk("rst_ppu_rvalid", int'(ppu_rvalid), 0);
        chk("rst_dma_rvalid", int'(dma_rvalid), 0);
        chk("rst_mem_wren", int'(mem_wren), 0);
        chk("rst_cpu_rdata", int'(cpu_rdata), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);

        // idle CPU read
        cpu_txn(1'b0, 13'h0010, 8'h00, 1'b0, lat, rd);
        chk("idle_read_latency", lat, 2);
        chk("idle_read_data", int'(rd), 'h5A);

        // blocked write, blocked read, then unlocked read of untouched location
        vram_access = 1'b1;
        wren_seen = 1'b0;
        cpu_txn(1'b1, 13'h0020, 8'h33, 1'b1, lat, rd);
        chk("blocked_write_latency", lat, 2);
        cpu_txn(1'b0, 13'h0020, 8'h00, 1'b1, lat, rd);
        chk("blocked_read_latency", lat, 2);
        chk("blocked_read_data", int'(rd), 'hFF);
        chk("blocked_no_wren", int'(wren_seen), 0);
        chk("blocked_mem_unchanged", int'(vram[13'h0020]), int'(pat(32)));
        vram_access = 1'b0;
        cpu_txn(1'b0, 13'h0020, 8'h00, 1'b0, lat, rd);
        chk("unlocked_read_data", int'(rd), int'(pat(32)));

        // CPU write then read back
        cpu_txn(1'b1, 13'h0030, 8'hC7, 1'b0, lat, rd);
        chk("write_latency", lat, 2);
        cpu_txn(1'b0, 13'h0030, 8'h00, 1'b0, lat, rd);
        chk("write_readback", int'(rd), 'hC7);

        // PPU priority: PPU busy for 10 cycles, CPU wins at cycle 10
        fork
            begin
                @(posedge clock); #1;
                for (int i = 0; i < 10; i++) begin
                    ppu_req = 1'b1; ppu_addr = 13'(16'h0100 + i);
                    @(posedge clock); #1;
                end
                ppu_req = 1'b0;
            end
            cpu_txn(1'b0, 13'h0180, 8'h00, 1'b0, lat, rd);
        join
        chk("ppu_priority_latency", lat, 11);
        chk("ppu_priority_data", int'(rd), int'(pat(13'h0180)));

        // starve override: DMA held, CPU wins on 9th wait cycle
        gvec = '0;
        fork
            begin
                @(posedge clock); #1;
                for (int c = 0; c < 25; c++) begin
                    dma_req = 1'b1; dma_addr = 13'(16'h0200 + c);
                    @(negedge clock);
                    gvec[c] = dma_gnt;
                    @(posedge clock); #1;
                end
                dma_req = 1'b0;
            end
            cpu_txn(1'b0, 13'h0280, 8'h00, 1'b0, lat, rd);
        join
        chk("starve_latency", lat, 10);
        chk("starve_data", int'(rd), int'(pat(13'h0280)));
        chk("starve_dma_gnt_pattern", int'(gvec), int'(25'h1FFFDFF));

        // reset while CPU waits behind DMA
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0300;
        dma_req = 1'b1; dma_addr = 13'h0040;
        @(posedge clock); #1;
        cpu_req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1; dma_req = 1'b0;
        @(negedge clock);
        chk("reset_cycle_no_ack", int'(cpu_ack), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_cpu_ack", int'(cpu_ack), 0);
        chk("post_reset_dma_rvalid", int'(dma_rvalid), 0);
        chk("post_reset_mem_wren", int'(mem_wren), 0);
        chk("post_reset_cpu_rdata", int'(cpu_rdata), 0);
        chk("post_reset_mem_addr", int'(mem_addr), 0);
        chk("post_reset_mem_wdata", int'(mem_wdata), 0);
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (cpu_ack) ack_cnt++;
        end
        chk("abandoned_txn_no_ack", ack_cnt, 0);

        // random traffic, lock released
        cpu_busy = 1'b0;
        dma_seen = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clock); #1;
            ppu_req  = ($urandom_range(3) == 0);
            ppu_addr = 13'($urandom_range(63));
            if (dma_req && dma_seen) dma_req = 1'b0;
            if (!dma_req && $urandom_range(2) == 0) begin
                dma_req  = 1'b1;
                dma_addr = 13'($urandom_range(63));
            end
            if (cpu_req) begin
                cpu_req = 1'b0;
            end else if (!cpu_busy && $urandom_range(3) == 0) begin
                cpu_ent_t e;
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(1));
                cpu_addr  = 13'($urandom_range(63));
                cpu_wdata = 8'($urandom_range(255));
                e.we = cpu_we; e.addr = cpu_addr; e.wdata = cpu_wdata;
                e.blk = 1'b0; e.exp = ref_mem[cpu_addr];
                cpu_q.push_back(e);
                cpu_busy = 1'b1;
            end
            @(negedge clock);
            dma_seen = dma_gnt;
            if (cpu_ack) cpu_busy = 1'b0;
        end
        @(posedge clock); #1;
        ppu_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (cpu_q.size() == 0 && ppu_q.size() == 0 && dma_q.size() == 0) break;
        end
        chk("drain_queues_empty", cpu_q.size() + ppu_q.size() + dma_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port 8 KB VRAM between three requesters: the PPU tile/map fetcher, the OAM DMA engine and the CPU bus. Fixed priority PPU > DMA > CPU, with a starvation override that lifts the CPU above DMA. The PPU's `vram_access` mode-3 lock is honoured: a CPU access that meets the lock completes without touching memory, returning 8'hFF on reads and dropping writes. Sits between `ppu`, the DMA unit, the CPU memory map and the VRAM instance.

## Interface
Parameters:
- `ADDR_W`, 13, VRAM address width
- `STARVE_LIMIT`, 8, consecutive CPU wait cycles before the CPU outranks DMA (1..15)

Ports:
- `clock`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `vram_access`  in  1  PPU lock; 1 = CPU may not touch VRAM
- `ppu_req`  in  1  PPU read request, one cycle per access
- `ppu_addr`  in  ADDR_W  PPU read address
- `ppu_gnt`  out  1  PPU served this cycle (combinational)
- `ppu_rvalid`  out  1  `ppu_rdata` valid; one cycle after `ppu_gnt`
- `ppu_rdata`  out  8  PPU read data
- `dma_req`  in  1  DMA read request, held until granted
- `dma_addr`  in  ADDR_W  DMA read address
- `dma_gnt`  out  1  DMA served this cycle (combinational)
- `dma_rvalid`  out  1  `dma_rdata` valid; one cycle after `dma_gnt`
- `dma_rdata`  out  8  DMA read data
- `cpu_req`  in  1  CPU request, level, sampled only in C_IDLE
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  8  CPU write data
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_rdata`  out  8  CPU read result, held until the next CPU read completes
- `mem_addr`  out  ADDR_W  VRAM address
- `mem_wdata`  out  8  VRAM write data
- `mem_wren`  out  1  VRAM write enable
- `mem_q`  in  8  VRAM read data, registered RAM, 1-cycle latency

## Operation
- **CPU FSM states: C_IDLE, C_WAIT, C_READ, C_DONE.**
  - C_IDLE: if `cpu_req`=1, latch `cpu_we`, `cpu_addr` and `cpu_wdata`, then go to C_WAIT.
  - C_WAIT, evaluated in order:
    - `vram_access`=1: go to C_DONE with blocked=1.
    - CPU wins arbitration: drive memory, then go to C_READ for a read or C_DONE for a write.
    - Otherwise stay in C_WAIT and increment the starve counter.
  - C_READ: latch `mem_q` into `cpu_rdata`, pulse `cpu_ack`, go to C_IDLE.
  - C_DONE: pulse `cpu_ack`. If the access was a blocked read, set `cpu_rdata` to 8'hFF. Go to C_IDLE.
- **Arbitration, per cycle, combinational:**
  - `ppu_gnt` = `ppu_req`.
  - `dma_gnt` = `dma_req` & ~`ppu_req` & ~(cpu_cand & starved).
  - cpu_cand = (state==C_WAIT) & ~`vram_access`.
  - The CPU wins if cpu_cand & ~`ppu_req` & (~`dma_req` | starved).
  - starved = (starve counter ≥ `STARVE_LIMIT`).
- **Starve counter:** 4 bits, saturating. Cleared on a CPU win and on leaving C_WAIT.
- **Memory drive:**
  - `mem_addr` comes from the winner; with no winner it holds the last value.
  - `mem_wren`=1 only in a CPU write-win cycle.
  - `mem_wdata` = latched `cpu_wdata`.
- **Read-data routing:** a registered owner tag (NONE/PPU/DMA/CPU) records the winner and steers `mem_q` in the following cycle. `ppu_rvalid` / `dma_rvalid` are registered copies of the corresponding grant. `ppu_rdata` / `dma_rdata` = `mem_q` combinationally, gated by the owner tag, 8'h00 otherwise.
- **Lock scope:** the PPU and DMA ignore `vram_access`; the lock restricts the CPU only.
- **PPU request without grant:** cannot occur (the PPU always wins).

## Timing
- **Reset values:** state C_IDLE, starve counter 0, owner NONE. `cpu_ack`, `ppu_rvalid`, `dma_rvalid` and `mem_wren` = 0. `cpu_rdata`, `mem_addr` and `mem_wdata` = 0.
  - `mem_wren` is forced 0 in any cycle where `reset`=1.
- **Reset mid-transaction:** the transaction is abandoned and no `cpu_ack` is issued.
- **CPU best case:** `cpu_req` at cycle 0 → C_WAIT and win at cycle 1 → `cpu_ack` at cycle 2. Read data is valid with the ack.
- **Blocked access:** `cpu_ack` follows 1 cycle after the C_WAIT cycle that sees the lock. No memory activity occurs.
- **Repeat requests:** a `cpu_req` still high in the cycle after `cpu_ack` starts a new transaction, because the FSM is back in C_IDLE.
- **PPU/DMA latency:** grant in cycle N → rvalid and rdata in cycle N+1. Back-to-back grants are allowed every cycle.
- **Lock edges:** `vram_access` rising while the CPU is in C_WAIT takes effect that same cycle. An already-granted CPU access completes normally.
- **Starve override:** the CPU outranks DMA on the cycle the counter reaches `STARVE_LIMIT`. The PPU still outranks it.
- **Simultaneous grants:** at most one of PPU / DMA / CPU wins per cycle; a bench must check this one-hot property every cycle.

## Test plan
- **Idle CPU read:** CPU reads 13'h0010 (mem holds 8'h5A) with no other traffic → `cpu_ack` at cycle 2, `cpu_rdata`=8'h5A.
- **Blocked CPU access:** CPU writes 8'h33 to 13'h0020 with `vram_access`=1 → ack after 2 cycles, `mem_wren` never 1, location unchanged. A following read under lock returns 8'hFF.
- **PPU priority:** `ppu_req` every cycle for 10 cycles plus a pending CPU read → CPU wins only after the PPU stops; every `ppu_rvalid` follows its `ppu_gnt` by exactly 1 cycle.
- **Starve override:** `dma_req` held continuously plus a CPU read, `STARVE_LIMIT`=8 → the CPU wins on its 9th C_WAIT cycle, `dma_gnt` is low in that cycle, and DMA resumes the next cycle.
- **Reset mid-transaction:** assert `reset` in C_WAIT → no `cpu_ack`, all outputs at reset values on the next cycle.
- **Random traffic:** random traffic on all three ports for 10k cycles → at most one winner per cycle, and the data every requester receives matches a reference memory model.
